fp_sqrt_iter: RTL and testbench

//   Multi-cycle unsigned fixed-point square root, digit-by-digit (radix-4 per cycle,
//   one result bit per cycle). Computes out = sqrt(in) with in/out in the same
//   UQ(WIDTH-FRAC_WIDTH).FRAC_WIDTH format. Sits behind the standard go/done group

---
 rtl/fp_sqrt_iter.sv | 175 +++++++++++++++++
 tb/tb_fp_sqrt_iter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_sqrt_iter.sv
// -----------------------------------------------------------------------------
// fp_sqrt_iter
//   Multi-cycle unsigned fixed-point square root. Each RUN cycle consumes the
//   next two radicand bits (radix-4 digit) and produces one result bit using
//   the restoring digit-by-digit method. The input and the output share the
//   UQ(WIDTH-FRAC_WIDTH).FRAC_WIDTH format, and FRAC_WIDTH=0 gives an integer
//   square root.
//
//   Configuration macro:
//     SQRT_ROUND_EN  defined   -> round to nearest, saturating at all-ones
//                    undefined -> truncate, out = floor(sqrt(X))
//
// Parameters
//   WIDTH       bit width of in/out
//   FRAC_WIDTH  fractional bits of in/out (WIDTH+FRAC_WIDTH must be even)
//
// Ports
//   clk    in   clock, all state updates on posedge
//   reset  in   synchronous active-high reset, drops any work in flight
//   go     in   start request, sampled only while idle
//   in     in   radicand, captured when go is accepted
//   out    out  result, held stable until the next completion
//   done   out  one-cycle pulse when out is updated
//   busy   out  high while an operation is being computed or finished
//
// Timing: go accepted at edge N; edges N+1..N+R compute; edge N+R+1 registers
// out and raises done. One operation per R+2 cycles. There is no early exit,
// so the latency is the same for every input.
// -----------------------------------------------------------------------------
module fp_sqrt_iter #(
  parameter int WIDTH      = 32,
  parameter int FRAC_WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             done,
  output logic             busy
);

  // Operand width, number of result bits, accumulator width, counter width
  localparam int XW = WIDTH + FRAC_WIDTH;
  localparam int R  = XW / 2;
  localparam int AW = R + 2;
  localparam int CW = $clog2(R + 1);

  localparam logic [CW-1:0] LAST_IDX = CW'(R - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [XW-1:0]    x_q;
  logic [AW-1:0]    acc_q;
  logic [R-1:0]     root_q;
  logic [CW-1:0]    idx_q;
  logic [WIDTH-1:0] out_q;
  logic             done_q;
  logic             busy_q;

  logic [XW-1:0]    x_load_s;
  logic [AW-1:0]    acc_sh_s;
  logic [AW:0]      trial_s;
  logic             trial_ok_s;
  logic [XW-1:0]    x_d;
  logic [AW-1:0]    acc_d;
  logic [R-1:0]     root_d;
  logic [CW-1:0]    idx_d;
  logic [WIDTH-1:0] root_ext_s;
  logic [WIDTH-1:0] result_s;

  // Radicand aligned so the binary point of the root lands on FRAC_WIDTH
  assign x_load_s = XW'(in) << FRAC_WIDTH;

  // One restoring iteration: bring in the next radicand digit and try to
  // subtract 4*root+1. The extra top bit of trial_s is the borrow; a clear
  // borrow means the new root bit is 1. The remainder never exceeds 2*root,
  // so the top two accumulator bits are always zero before the shift and the
  // truncation in the cast loses nothing.
  always_comb begin
    acc_sh_s   = AW'({acc_q, x_q[XW-1 -: 2]});
    trial_s    = {1'b0, acc_sh_s} - {1'b0, root_q, 2'b01};
    trial_ok_s = ~trial_s[AW];
    x_d        = x_q << 2;
    idx_d      = idx_q + CW'(1);
    if (trial_ok_s) begin
      acc_d = trial_s[AW-1:0];
    end else begin
      acc_d = acc_sh_s;
    end
    root_d = R'({root_q, trial_ok_s});
  end

  // Final result: zero-extend the R-bit root, optionally round to nearest.
  // After the last step acc_q holds the exact remainder X - root^2. Because
  // root^2 + root + 0.25 never lies on an integer, rem > root is exactly the
  // condition sqrt(X) >= root + 0.5.
  always_comb begin
    root_ext_s = WIDTH'(root_q);
`ifdef SQRT_ROUND_EN
    if ((acc_q > AW'(root_q)) && (root_ext_s != {WIDTH{1'b1}})) begin
      result_s = root_ext_s + WIDTH'(1);
    end else begin
      result_s = root_ext_s;
    end
`else
    result_s = root_ext_s;
`endif
  end

  // Control FSM with the datapath registers and the registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      acc_q   <= '0;
      root_q  <= '0;
      idx_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (go) begin
            x_q     <= x_load_s;
            acc_q   <= '0;
            root_q  <= '0;
            idx_q   <= '0;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          done_q <= 1'b0;
          busy_q <= 1'b1;
          x_q    <= x_d;
          acc_q  <= acc_d;
          root_q <= root_d;
          idx_q  <= idx_d;
          if (idx_q == LAST_IDX) begin
            state_q <= S_DONE;
          end else begin
            state_q <= S_RUN;
          end
        end
        S_DONE: begin
          // go is ignored here; a held go restarts from IDLE next cycle
          out_q   <= result_s;
          done_q  <= 1'b1;
          busy_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign out  = out_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_fp_sqrt_iter.sv
module tb_fp_sqrt_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        go_a, go_b, go_c;
  logic [31:0] in_a, in_b;
  logic [7:0]  in_c;
  logic [31:0] out_a, out_b;
  logic [7:0]  out_c;
  logic        done_a, done_b, done_c;
  logic        busy_a, busy_b, busy_c;

  int total = 0;
  int bad   = 0;

  // cfg 0: (32,16)  cfg 1: (32,0)  cfg 2: (8,8)
  fp_sqrt_iter #(.WIDTH(32), .FRAC_WIDTH(16)) dut_a (
    .clk(clk), .reset(reset), .go(go_a), .in(in_a),
    .out(out_a), .done(done_a), .busy(busy_a));
  fp_sqrt_iter #(.WIDTH(32), .FRAC_WIDTH(0)) dut_b (
    .clk(clk), .reset(reset), .go(go_b), .in(in_b),
    .out(out_b), .done(done_b), .busy(busy_b));
  fp_sqrt_iter #(.WIDTH(8), .FRAC_WIDTH(8)) dut_c (
    .clk(clk), .reset(reset), .go(go_c), .in(in_c),
    .out(out_c), .done(done_c), .busy(busy_c));

  function automatic int cfg_w(int cfg);
    return (cfg == 2) ? 8 : 32;
  endfunction

  function automatic int cfg_f(int cfg);
    case (cfg)
      0:       return 16;
      1:       return 0;
      default: return 8;
    endcase
  endfunction

  function automatic int cfg_r(int cfg);
    return (cfg_w(cfg) + cfg_f(cfg)) / 2;
  endfunction

  function automatic logic [31:0] cur_out(int cfg);
    case (cfg)
      0:       return out_a;
      1:       return out_b;
      default: return {24'd0, out_c};
    endcase
  endfunction

  function automatic logic cur_done(int cfg);
    case (cfg)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  function automatic logic cur_busy(int cfg);
    case (cfg)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  task automatic set_go(input int cfg, input logic v, input logic [31:0] val);
    case (cfg)
      0:       begin go_a = v; in_a = val;       end
      1:       begin go_b = v; in_b = val;       end
      default: begin go_c = v; in_c = val[7:0];  end
    endcase
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: sqrt of X = in * 2^F by binary search on plain integers
  function automatic longint unsigned ref_sqrt(int w, int f, longint unsigned v);
    longint unsigned x, lo, hi, mid, r;
`ifdef SQRT_ROUND_EN
    longint unsigned maxv;
`endif
    x  = v << f;
    lo = 0;
    hi = 64'd1 << ((w + f) / 2);
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= x) lo = mid;
      else hi = mid;
    end
    r = lo;
`ifdef SQRT_ROUND_EN
    maxv = (64'd1 << w) - 1;
    if (x - r * r > r) r = r + 1;
    if (r > maxv) r = maxv;
`endif
    return r;
  endfunction

  // One operation: checks latency R+1, busy across the run, idle afterwards
  task automatic run_op(input int cfg, input logic [31:0] val, input string tag,
                        output logic [31:0] res);
    int  k;
    bit  seen;
    bit  busy_ok;
    int  r;
    r = cfg_r(cfg);
    @(negedge clk);
    set_go(cfg, 1'b1, val);
    @(posedge clk);
    @(negedge clk);
    // input changes after acceptance must be ignored
    set_go(cfg, 1'b0, ~val);
    busy_ok = (cur_busy(cfg) === 1'b0) && (cur_done(cfg) === 1'b0);
    k = 0;
    seen = 0;
    while (!seen && k < r + 10) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (cur_busy(cfg) !== 1'b1) busy_ok = 0;
      if (cur_done(cfg) === 1'b1) seen = 1;
    end
    check({tag, "_latency"}, 64'(k), 64'(r + 1));
    check({tag, "_busy"}, 64'(busy_ok), 64'd1);
    res = cur_out(cfg);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_after"}, {62'd0, cur_done(cfg), cur_busy(cfg)}, 64'd0);
    check({tag, "_hold"}, 64'(cur_out(cfg)), 64'(res));
  endtask

  typedef struct {
    int          cfg;
    logic [31:0] din;
    logic [31:0] exp_t;
    logic [31:0] exp_r;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [31:0] res;
    logic [31:0] exp;
    logic [31:0] val;
    int          pulses[$];
    int          cyc;
    bit          prev_done;
    bit          consec;

    vecs[0]  = '{0, 32'h0004_0000, 32'h0002_0000, 32'h0002_0000};
    vecs[1]  = '{0, 32'h0002_0000, 32'h0001_6A09, 32'h0001_6A0A};
    vecs[2]  = '{1, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'h0001_0000};
    vecs[3]  = '{0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[4]  = '{1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[5]  = '{2, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[6]  = '{2, 32'h0000_00FF, 32'h0000_00FF, 32'h0000_00FF};
    vecs[7]  = '{2, 32'h0000_0040, 32'h0000_0080, 32'h0000_0080};
    vecs[8]  = '{0, 32'hFFFF_FFFF, 32'h00FF_FFFF, 32'h0100_0000};
    vecs[9]  = '{1, 32'h0000_0007, 32'h0000_0002, 32'h0000_0003};
    vecs[10] = '{2, 32'h0000_0002, 32'h0000_0016, 32'h0000_0017};
    vecs[11] = '{1, 32'h0000_0090, 32'h0000_000C, 32'h0000_000C};

    reset = 1'b1;
    go_a = 1'b0; go_b = 1'b0; go_c = 1'b0;
    in_a = 32'd0; in_b = 32'd0; in_c = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("reset_out_cfg%0d", c), 64'(cur_out(c)), 64'd0);
      check($sformatf("reset_flags_cfg%0d", c), {62'd0, cur_done(c), cur_busy(c)}, 64'd0);
    end
    reset = 1'b0;

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
`ifdef SQRT_ROUND_EN
      exp = vecs[i].exp_r;
`else
      exp = vecs[i].exp_t;
`endif
      run_op(vecs[i].cfg, vecs[i].din, $sformatf("vec%0d", i), res);
      check($sformatf("vec%0d_out", i), 64'(res), 64'(exp));
    end

    // go held high: three back-to-back ops, done pulses R+2 apart
    @(negedge clk);
    go_a = 1'b1;
    in_a = 32'h0009_0000;
    cyc = 0;
    prev_done = 0;
    consec = 0;
    while (pulses.size() < 3 && cyc < 150) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (done_a === 1'b1) begin
        if (prev_done) consec = 1;
        pulses.push_back(cyc);
        check($sformatf("held_out%0d", pulses.size()), 64'(out_a), 64'h0003_0000);
      end
      prev_done = (done_a === 1'b1);
    end
    go_a = 1'b0;
    check("held_pulse_count", 64'(pulses.size()), 64'd3);
    if (pulses.size() == 3) begin
      check("held_gap1", 64'(pulses[1] - pulses[0]), 64'd26);
      check("held_gap2", 64'(pulses[2] - pulses[1]), 64'd26);
    end
    check("held_no_consec", 64'(consec), 64'd0);
    repeat (30) @(posedge clk);

    // Reset in the middle of a run
    @(negedge clk);
    go_a = 1'b1;
    in_a = 32'h0019_0000;
    @(posedge clk);
    @(negedge clk);
    go_a = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrun_reset_out", 64'(out_a), 64'd0);
    check("midrun_reset_flags", {62'd0, done_a, busy_a}, 64'd0);
    reset = 1'b0;
    run_op(0, 32'h0010_0000, "post_reset", res);
    check("post_reset_out", 64'(res), 64'h0004_0000);

    // Randomized against the reference model
    for (int c = 0; c < 3; c++) begin
      for (int j = 0; j < 15; j++) begin
        val = $urandom;
        if (j % 4 == 1) val = val >> $urandom_range(28, 4);
        if (c == 2) val = val & 32'h0000_00FF;
        run_op(c, val, $sformatf("rnd_c%0d_%0d", c, j), res);
        exp = 32'(ref_sqrt(cfg_w(c), cfg_f(c), 64'(val)));
        check($sformatf("rnd_c%0d_%0d_in%0h", c, j, val), 64'(res), 64'(exp));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
